session_timer: RTL and testbench

Customer-session countdown for the vending machine. It consumes the 1 Hz square wave from the clock divider and counts down a per-session timeout. Any customer activity restarts the countdown. It signals a warning window, a one-cycle timeout event, and a held expired flag that the main controller acknowledges. The remaining-seconds count feeds the display path.

---
 rtl/session_timer.sv | 124 ++++++++++++
 tb/tb_session_timer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/session_timer.sv
// Customer-session countdown driven by the 1 Hz divider output.
// Tracks remaining seconds and flags warning, timeout and expiry.
module session_timer #(
    parameter int TIMEOUT_S = 30,
    parameter int WARN_S    = 5,
    parameter int CW        = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_1hz,
    input  logic          start,
    input  logic          activity,
    input  logic          cancel,
    input  logic          ack,
    output logic [CW-1:0] remaining,
    output logic [1:0]    state,
    output logic          warn,
    output logic          timeout,
    output logic          expired
);

    if (TIMEOUT_S > (1 << CW) - 1 || WARN_S >= TIMEOUT_S || WARN_S == 0)
    begin : g_bad_params
        $error("session_timer: illegal TIMEOUT_S/WARN_S/CW");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        WARN    = 2'b10,
        EXPIRED = 2'b11
    } st_e;

    localparam logic [CW-1:0] T_LD = CW'(TIMEOUT_S);
    localparam logic [CW-1:0] W_LD = CW'(WARN_S);
    localparam logic [CW-1:0] ONE  = CW'(1);

    st_e           st_q, st_n;
    logic [CW-1:0] rem_q, rem_n, rem_dec;
    logic          tick_d, sec;
    logic          warn_q, warn_n;
    logic          tmo_q, tmo_n;
    logic          exp_q, exp_n;

    assign sec     = tick_1hz & ~tick_d;
    assign rem_dec = rem_q - ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= IDLE;
            rem_q  <= T_LD;
            tick_d <= 1'b1;
            warn_q <= 1'b0;
            tmo_q  <= 1'b0;
            exp_q  <= 1'b0;
        end else begin
            st_q   <= st_n;
            rem_q  <= rem_n;
            tick_d <= tick_1hz;
            warn_q <= warn_n;
            tmo_q  <= tmo_n;
            exp_q  <= exp_n;
        end
    end

    // Event priority: cancel, then activity, then the one-second strobe.
    always_comb begin
        st_n  = st_q;
        rem_n = rem_q;
        unique case (st_q)
            IDLE: begin
                rem_n = T_LD;
                if (start) st_n = RUN;
            end
            RUN: begin
                if (cancel) begin
                    st_n  = IDLE;
                    rem_n = T_LD;
                end else if (activity) begin
                    rem_n = T_LD;
                end else if (sec && rem_q != '0) begin
                    rem_n = rem_dec;
                    if (rem_dec == W_LD) st_n = WARN;
                end
            end
            WARN: begin
                if (cancel) begin
                    st_n  = IDLE;
                    rem_n = T_LD;
                end else if (activity) begin
                    st_n  = RUN;
                    rem_n = T_LD;
                end else if (sec && rem_q != '0) begin
                    rem_n = rem_dec;
                    if (rem_q == ONE) st_n = EXPIRED;
                end
            end
            EXPIRED: begin
                rem_n = '0;
                if (ack || cancel) begin
                    st_n  = IDLE;
                    rem_n = T_LD;
                end
            end
            default: begin
                st_n  = IDLE;
                rem_n = T_LD;
            end
        endcase
    end

    always_comb begin
        warn_n = (st_n == WARN);
        exp_n  = (st_n == EXPIRED);
        tmo_n  = (st_n == EXPIRED) && (st_q != EXPIRED);
    end

    assign remaining = rem_q;
    assign state     = st_q;
    assign warn      = warn_q;
    assign timeout   = tmo_q;
    assign expired   = exp_q;

endmodule

// File: tb/tb_session_timer.sv
// Randomised and directed bench for session_timer.
// Reference model predicts outputs; monitor compares every cycle.
module tb_session_timer;

    localparam int T  = 30;
    localparam int W  = 5;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick_1hz = 1'b0;
    logic          start = 1'b0;
    logic          activity = 1'b0;
    logic          cancel = 1'b0;
    logic          ack = 1'b0;
    logic [CW-1:0] remaining;
    logic [1:0]    state;
    logic          warn;
    logic          timeout;
    logic          expired;

    session_timer #(.TIMEOUT_S(T), .WARN_S(W), .CW(CW)) dut (
        .clk(clk),
        .rst(rst),
        .tick_1hz(tick_1hz),
        .start(start),
        .activity(activity),
        .cancel(cancel),
        .ack(ack),
        .remaining(remaining),
        .state(state),
        .warn(warn),
        .timeout(timeout),
        .expired(expired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] rem;
        logic [1:0]    st;
        logic          w;
        logic          t;
        logic          e;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model: session phase 0 idle, 1 running, 2 warning, 3 expired.
    int m_phase = 0;
    int m_left  = T;
    bit m_prev_tick = 1'b1;
    bit m_pulse = 1'b0;

    function automatic void model_step();
        bit sec;
        m_pulse = 1'b0;
        if (rst) begin
            m_phase = 0;
            m_left = T;
            m_prev_tick = 1'b1;
            return;
        end
        sec = tick_1hz && !m_prev_tick;
        m_prev_tick = tick_1hz;
        if (m_phase == 0) begin
            if (start) m_phase = 1;
        end else if (m_phase == 3) begin
            if (ack || cancel) begin
                m_phase = 0;
                m_left = T;
            end
        end else if (cancel) begin
            m_phase = 0;
            m_left = T;
        end else if (activity) begin
            m_phase = 1;
            m_left = T;
        end else if (sec) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_phase = 3;
                m_pulse = 1'b1;
            end else if (m_left <= W) begin
                m_phase = 2;
            end
        end
    endfunction

    task automatic step();
        exp_t e;
        model_step();
        e.rem = CW'(m_left);
        e.st  = 2'(m_phase);
        e.w   = (m_phase == 2);
        e.t   = m_pulse;
        e.e   = (m_phase == 3);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            steps(2);
            tick_1hz = 1'b0;
            steps(2);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: outputs settle just after each edge; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if ({remaining, state, warn, timeout, expired} != e) begin
                    miscompares++;
                    $display("FAIL cycle t=%0t: rem/st/w/t/e got %0d/%0d/%0b/%0b/%0b required %0d/%0d/%0b/%0b/%0b",
                             $time, remaining, state, warn, timeout, expired,
                             e.rem, e.st, e.w, e.t, e.e);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        steps(2);
        rst = 1'b0;
        steps(2);
        chk("reset_state", int'(state), 0);
        chk("reset_rem", int'(remaining), T);

        // Full expiry
        pulse_start();
        ticks(25);
        chk("warn_state", int'(state), 2);
        chk("warn_rem", int'(remaining), W);
        chk("warn_flag", int'(warn), 1);
        ticks(5);
        chk("exp_state", int'(state), 3);
        chk("exp_rem", int'(remaining), 0);
        chk("exp_flag", int'(expired), 1);
        chk("timeout_one_cycle", int'(timeout), 0);
        ack = 1'b1; step(); ack = 1'b0;
        step();
        chk("ack_idle", int'(state), 0);
        chk("ack_rem", int'(remaining), T);

        // Activity restart from warning
        pulse_start();
        ticks(27);
        chk("warn3_rem", int'(remaining), 3);
        activity = 1'b1; step(); activity = 1'b0;
        chk("restart_rem", int'(remaining), T);
        chk("restart_state", int'(state), 1);
        chk("restart_warn", int'(warn), 0);

        // Activity and second together at 12
        ticks(18);
        chk("at12", int'(remaining), 12);
        tick_1hz = 1'b1; activity = 1'b1; step(); activity = 1'b0;
        step(); tick_1hz = 1'b0; steps(2);
        chk("act_beats_sec", int'(remaining), T);
        cancel = 1'b1; activity = 1'b1; step();
        cancel = 1'b0; activity = 1'b0;
        chk("cancel_beats_act", int'(state), 0);

        // Ignored inputs in IDLE, RUN and EXPIRED
        activity = 1'b1; ticks(3); activity = 1'b0;
        chk("idle_hold_rem", int'(remaining), T);
        chk("idle_hold_st", int'(state), 0);
        pulse_start();
        ticks(10);
        pulse_start();
        step();
        chk("start_in_run", int'(remaining), 20);
        ticks(20);
        activity = 1'b1; ticks(2); activity = 1'b0;
        chk("late_coin_st", int'(state), 3);
        chk("late_coin_rem", int'(remaining), 0);
        cancel = 1'b1; step(); cancel = 1'b0;

        // Tick held high across reset release
        rst = 1'b1; tick_1hz = 1'b1; steps(2);
        rst = 1'b0; steps(2);
        pulse_start();
        steps(4);
        chk("no_false_edge", int'(remaining), T);
        tick_1hz = 1'b0; steps(2);
        tick_1hz = 1'b1; steps(2);
        tick_1hz = 1'b0; steps(2);
        chk("first_real_edge", int'(remaining), T - 1);

        // Reset in warning at 4
        ticks(25);
        chk("warn4", int'(remaining), 4);
        rst = 1'b1;
        #1;
        chk("async_rst_st", int'(state), 0);
        chk("async_rst_rem", int'(remaining), T);
        chk("async_rst_tmo", int'(timeout), 0);
        steps(2);
        rst = 1'b0;
        steps(2);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) tick_1hz = ~tick_1hz;
            start    = ($urandom_range(15) == 0);
            activity = ($urandom_range(40) == 0);
            cancel   = ($urandom_range(150) == 0);
            ack      = ($urandom_range(10) == 0);
            rst      = ($urandom_range(800) == 0);
            step();
        end
        {start, activity, cancel, ack, rst} = '0;
        steps(2);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
